// File: rtl/spi_reg_interface.sv
// spi_reg_interface: SPI mode-0 write-only slave feeding the PWM configuration registers.
// Pins are synchronized into clk; 16-bit frames {rw, addr[6:0], data[7:0]} are
// committed on the chip-select rising edge when well formed.
module spi_reg_interface #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err
);

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = FRAME_BITS + 1;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned RW_BIT     = FRAME_BITS - 1;
  localparam int unsigned ADDR_LSB   = DATA_W;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;
  logic                   r_ncs_seen_high;

  logic [FRAME_BITS-1:0]  r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_armed;

  logic [DATA_W-1:0]      r_reg0;
  logic [DATA_W-1:0]      r_reg1;
  logic [DATA_W-1:0]      r_reg2;
  logic [DATA_W-1:0]      r_reg3;
  logic [DATA_W-1:0]      r_reg4;
  logic                   r_frame_done;
  logic                   r_frame_err;

  logic                   w_sclk;
  logic                   w_copi;
  logic                   w_ncs;
  logic                   w_sclk_rise;
  logic                   w_ncs_fall;
  logic                   w_ncs_rise;
  logic [ADDR_W-1:0]      w_addr;
  logic [DATA_W-1:0]      w_data;
  logic                   w_commit_ok;
  logic                   w_close;

  // Input synchronizers; r_sync_vld marks when the chains carry real pin samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_copi_sync <= '0;
      r_ncs_sync  <= '1;
      r_sync_vld  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_copi = r_copi_sync[SYNC_STAGES-1];
  assign w_ncs  = r_ncs_sync[SYNC_STAGES-1];

  // Edge-detect history; ncs must be seen truly high after reset before a fall can arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_prev     <= 1'b0;
      r_ncs_prev      <= 1'b1;
      r_ncs_seen_high <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_ncs_prev  <= w_ncs;
      if (r_sync_vld[SYNC_STAGES-1] && w_ncs) begin
        r_ncs_seen_high <= 1'b1;
      end
    end
  end

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_ncs_fall  = ~w_ncs & r_ncs_prev & r_ncs_seen_high;
  assign w_ncs_rise  = w_ncs & ~r_ncs_prev;

  assign w_addr      = r_shift[ADDR_LSB +: ADDR_W];
  assign w_data      = r_shift[DATA_W-1:0];
  assign w_close     = w_ncs_rise & r_armed;
  assign w_commit_ok = (r_bit_cnt == CNT_W'(FRAME_BITS)) && r_shift[RW_BIT] &&
                       (w_addr <= ADDR_W'(MAX_ADDR));

  // Frame capture: arm on ncs fall, shift on qualified sclk rise, disarm on ncs rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_armed   <= 1'b0;
    end else if (w_ncs_fall) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_armed   <= 1'b1;
    end else if (w_close) begin
      r_armed   <= 1'b0;
    end else if (w_sclk_rise && !w_ncs && r_armed) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
      if (r_bit_cnt != CNT_W'(CNT_SAT)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Register file update and one-cycle status pulses at frame close.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg0       <= '0;
      r_reg1       <= '0;
      r_reg2       <= '0;
      r_reg3       <= '0;
      r_reg4       <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_close) begin
        if (w_commit_ok) begin
          r_frame_done <= 1'b1;
          case (w_addr)
            ADDR_W'(0): r_reg0 <= w_data;
            ADDR_W'(1): r_reg1 <= w_data;
            ADDR_W'(2): r_reg2 <= w_data;
            ADDR_W'(3): r_reg3 <= w_data;
            ADDR_W'(4): r_reg4 <= w_data;
            default:    ;
          endcase
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;
  assign frame_done      = r_frame_done;
  assign frame_err       = r_frame_err;

endmodule
